// File: rtl/cavlc_coef_scanner.sv
// Reverse-scan analysis of one 4x4 residual block for CAVLC: collects TotalCoeff,
// TrailingOnes/signs, level list, total zeros and run_before list, one coefficient per cycle.
module cavlc_coef_scanner #(
    parameter int COEF_W   = 16,
    parameter int NUM_COEF = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] coef_in [0:NUM_COEF-1],
    output logic                     out_valid,
    output logic                     done,
    output logic [4:0]               total_coeff,
    output logic [1:0]               trailing_ones,
    output logic [2:0]               t1_signs,
    output logic [4:0]               total_zero_cnt,
    output logic [4:0]               runbefore_cnt,
    output logic [4:0]               runbefore_list [0:15],
    output logic signed [COEF_W-1:0] level_list [0:15]
);

    localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam logic signed [COEF_W-1:0] POS_ONE = COEF_W'(1);
    localparam logic signed [COEF_W-1:0] NEG_ONE = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [COEF_W-1:0]  buf_q [0:NUM_COEF-1];
    logic signed [COEF_W-1:0]  buf_d [0:NUM_COEF-1];
    logic signed [COEF_W-1:0]  level_q [0:15];
    logic signed [COEF_W-1:0]  level_d [0:15];
    logic [4:0]                rb_q [0:15];
    logic [4:0]                rb_d [0:15];
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4:0]                tc_q, tc_d;
    logic [4:0]                tz_q, tz_d;
    logic [4:0]                zr_q, zr_d;
    logic [1:0]                t1_q, t1_d;
    logic [2:0]                t1s_q, t1s_d;
    logic                      nz_q, nz_d;
    logic                      t1_stop_q, t1_stop_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      done_q, done_d;
    logic signed [COEF_W-1:0]  c;
    logic [3:0]                prev_idx;
    logic [3:0]                last_idx;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        level_d   = level_q;
        rb_d      = rb_q;
        idx_d     = idx_q;
        tc_d      = tc_q;
        tz_d      = tz_q;
        zr_d      = zr_q;
        t1_d      = t1_q;
        t1s_d     = t1s_q;
        nz_d      = nz_q;
        t1_stop_d = t1_stop_q;
        done_d    = 1'b0;
        c         = buf_q[idx_q];
        prev_idx  = tc_q[3:0] - 4'd1;
        last_idx  = '0;

        case (state_q)
            IDLE, DONE: begin
                if (in_valid && in_ready_q) begin
                    buf_d     = coef_in;
                    level_d   = '{default: '0};
                    rb_d      = '{default: '0};
                    idx_d     = IDX_W'(NUM_COEF - 1);
                    tc_d      = '0;
                    tz_d      = '0;
                    zr_d      = '0;
                    t1_d      = '0;
                    t1s_d     = '0;
                    nz_d      = 1'b0;
                    t1_stop_d = 1'b0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (c == '0) begin
                    if (nz_q) begin
                        zr_d = zr_q + 5'd1;
                        tz_d = tz_q + 5'd1;
                    end
                end else begin
                    level_d[tc_q[3:0]] = c;
                    if (nz_q) begin
                        rb_d[prev_idx] = zr_q;
                        zr_d           = '0;
                    end
                    tc_d = tc_q + 5'd1;
                    nz_d = 1'b1;
                    if ((c == POS_ONE || c == NEG_ONE) && !t1_stop_q && t1_q < 2'd3) begin
                        t1s_d[t1_q] = c[COEF_W-1];
                        t1_d        = t1_q + 2'd1;
                    end else begin
                        t1_stop_d = 1'b1;
                    end
                end
                if (idx_q == '0) begin
                    // tc_d of 16 wraps to 0 in 4 bits, so minus one lands on entry 15
                    last_idx = tc_d[3:0] - 4'd1;
                    if (nz_d) rb_d[last_idx] = zr_d;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d != SCAN);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            buf_q       <= '{default: '0};
            level_q     <= '{default: '0};
            rb_q        <= '{default: '0};
            idx_q       <= '0;
            tc_q        <= '0;
            tz_q        <= '0;
            zr_q        <= '0;
            t1_q        <= '0;
            t1s_q       <= '0;
            nz_q        <= 1'b0;
            t1_stop_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            level_q     <= level_d;
            rb_q        <= rb_d;
            idx_q       <= idx_d;
            tc_q        <= tc_d;
            tz_q        <= tz_d;
            zr_q        <= zr_d;
            t1_q        <= t1_d;
            t1s_q       <= t1s_d;
            nz_q        <= nz_d;
            t1_stop_q   <= t1_stop_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign done           = done_q;
    assign total_coeff    = tc_q;
    assign runbefore_cnt  = tc_q;
    assign trailing_ones  = t1_q;
    assign t1_signs       = t1s_q;
    assign total_zero_cnt = tz_q;
    assign runbefore_list = rb_q;
    assign level_list     = level_q;

endmodule

// File: tb/tb_cavlc_coef_scanner.sv
// Randomized and directed bench for cavlc_coef_scanner (16- and 4-coefficient builds)
// against a list-based reference model.
module tb_cavlc_coef_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid;
    logic use4;
    logic signed [15:0] blk  [0:15];
    logic signed [15:0] blk4 [0:3];

    logic iv16, iv4;
    logic rdy16, ov16, dn16, rdy4, ov4, dn4;
    logic [4:0] tc16, tz16, rbc16, tc4, tz4, rbc4;
    logic [1:0] t1_16, t1_4;
    logic [2:0] sg16, sg4;
    logic [4:0] rb16 [0:15];
    logic [4:0] rb4  [0:15];
    logic signed [15:0] lv16 [0:15];
    logic signed [15:0] lv4  [0:15];

    logic obs_rdy, obs_ov, obs_dn;
    logic [4:0] obs_tc, obs_tz, obs_rbc;
    logic [1:0] obs_t1;
    logic [2:0] obs_sg;
    logic [4:0] obs_rb [0:15];
    logic signed [15:0] obs_lv [0:15];

    int checks = 0;
    int failures = 0;

    int exp_tc, exp_t1, exp_tz;
    logic [2:0] exp_sg;
    int exp_rb [0:15];
    logic signed [15:0] exp_lv [0:15];

    assign iv16 = in_valid && !use4;
    assign iv4  = in_valid && use4;

    always_comb begin
        for (int i = 0; i < 4; i++) blk4[i] = blk[i];
    end

    cavlc_coef_scanner #(.COEF_W(16), .NUM_COEF(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .coef_in(blk),
        .out_valid(ov16), .done(dn16), .total_coeff(tc16), .trailing_ones(t1_16),
        .t1_signs(sg16), .total_zero_cnt(tz16), .runbefore_cnt(rbc16),
        .runbefore_list(rb16), .level_list(lv16));

    cavlc_coef_scanner #(.COEF_W(16), .NUM_COEF(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .coef_in(blk4),
        .out_valid(ov4), .done(dn4), .total_coeff(tc4), .trailing_ones(t1_4),
        .t1_signs(sg4), .total_zero_cnt(tz4), .runbefore_cnt(rbc4),
        .runbefore_list(rb4), .level_list(lv4));

    always_comb begin
        obs_rdy = use4 ? rdy4 : rdy16;
        obs_ov  = use4 ? ov4  : ov16;
        obs_dn  = use4 ? dn4  : dn16;
        obs_tc  = use4 ? tc4  : tc16;
        obs_tz  = use4 ? tz4  : tz16;
        obs_rbc = use4 ? rbc4 : rbc16;
        obs_t1  = use4 ? t1_4 : t1_16;
        obs_sg  = use4 ? sg4  : sg16;
        for (int i = 0; i < 16; i++) begin
            obs_rb[i] = use4 ? rb4[i] : rb16[i];
            obs_lv[i] = use4 ? lv4[i] : lv16[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: list nonzero positions from the top down, then derive every field from that list.
    task automatic ref_model(input int n);
        int pos[$];
        bit stop;
        pos.delete();
        for (int i = n - 1; i >= 0; i--) if (blk[i] != 0) pos.push_back(i);
        exp_tc = pos.size();
        exp_t1 = 0;
        exp_sg = '0;
        stop   = 0;
        for (int k = 0; k < 16; k++) begin
            exp_lv[k] = '0;
            exp_rb[k] = 0;
        end
        for (int k = 0; k < pos.size(); k++) begin
            exp_lv[k] = blk[pos[k]];
            exp_rb[k] = (k < pos.size() - 1) ? pos[k] - pos[k+1] - 1 : pos[k];
            if (!stop && exp_t1 < 3 && (blk[pos[k]] == 1 || blk[pos[k]] == -1)) begin
                exp_sg[exp_t1] = (blk[pos[k]] < 0);
                exp_t1++;
            end else begin
                stop = 1;
            end
        end
        exp_tz = (pos.size() > 0) ? pos[0] + 1 - pos.size() : 0;
    endtask

    task automatic check_results(input int n);
        ref_model(n);
        check("out_valid", 32'(obs_ov), 32'd1);
        check("total_coeff", 32'(obs_tc), 32'(exp_tc));
        check("trailing_ones", 32'(obs_t1), 32'(exp_t1));
        check("t1_signs", 32'(obs_sg), 32'(exp_sg));
        check("total_zero_cnt", 32'(obs_tz), 32'(exp_tz));
        check("runbefore_cnt", 32'(obs_rbc), 32'(exp_tc));
        for (int k = 0; k < 16; k++) begin
            check($sformatf("rb%0d", k), 32'(obs_rb[k]), 32'(exp_rb[k]));
            check($sformatf("lv%0d", k), 32'(obs_lv[k]), 32'(exp_lv[k]));
        end
    endtask

    task automatic wait_accept();
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        guard = 0;
        while (!obs_rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(obs_rdy), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n);
        int lat;
        bit ovlow;
        lat = 0;
        ovlow = 1;
        while (!obs_dn && lat < 40) begin
            if (obs_ov) ovlow = 0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(n));
        check("ov_low_in_scan", 32'(ovlow), 32'd1);
    endtask

    task automatic run_block(input int n);
        wait_accept();
        in_valid = 1'b0;
        wait_done(n);
        check_results(n);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(obs_dn), 32'd0);
        check("ov_hold", 32'(obs_ov), 32'd1);
    endtask

    function automatic logic signed [15:0] rnd_coef();
        logic signed [15:0] v;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: v = 16'sd0;
            5, 6:          v = ($urandom_range(0, 1) != 0) ? 16'sd1 : -16'sd1;
            7:             v = ($urandom_range(0, 1) != 0) ? 16'sd2 : -16'sd2;
            8:             v = 16'($urandom);
            default:       v = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7fff;
        endcase
        return v;
    endfunction

    task automatic clear_blk();
        for (int i = 0; i < 16; i++) blk[i] = '0;
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 16; i++) blk[i] = rnd_coef();
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        use4 = 1'b0;
        clear_blk();
        #2;
        check("rst_ready", 32'(rdy16), 32'd0);
        check("rst_ov", 32'(ov16), 32'd0);
        check("rst_tc", 32'(tc16), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(rdy16), 32'd1);

        // worked example
        clear_blk();
        blk[1] = 16'sd3;  blk[2] = -16'sd1; blk[5] = -16'sd1;
        blk[6] = 16'sd1;  blk[8] = 16'sd1;
        run_block(16);
        check("ex_tc", 32'(obs_tc), 32'd5);
        check("ex_sg", 32'(obs_sg), 32'b100);
        check("ex_rb0", 32'(obs_rb[0]), 32'd1);
        check("ex_rb2", 32'(obs_rb[2]), 32'd2);
        check("ex_tz", 32'(obs_tz), 32'd4);

        clear_blk();
        run_block(16);

        for (int i = 0; i < 16; i++) blk[i] = 16'sd2;
        run_block(16);

        clear_blk();
        blk[0] = -16'sd1;
        run_block(16);

        clear_blk();
        blk[15] = 16'sd5;
        run_block(16);
        check("top_rb0", 32'(obs_rb[0]), 32'd15);

        for (int r = 0; r < 25; r++) begin
            rand_blk();
            run_block(16);
        end

        // reset in the middle of a scan
        rand_blk();
        blk[15] = 16'sd7; blk[14] = 16'sd1; blk[13] = -16'sd3; blk[12] = 16'sd4; blk[11] = 16'sd9;
        wait_accept();
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_tc", 32'(tc16), 32'd0);
        check("mid_rst_lv0", 32'(lv16[0]), 32'd0);
        check("mid_rst_ready", 32'(rdy16), 32'd0);
        check("mid_rst_done", 32'(dn16), 32'd0);
        check("mid_rst_ov", 32'(ov16), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready_after", 32'(rdy16), 32'd1);
        rand_blk();
        run_block(16);

        // back-to-back with in_valid held high and junk presented during the scan
        rand_blk();
        wait_accept();
        ref_model(16);
        begin
            logic signed [15:0] saved [0:15];
            logic signed [15:0] nxt   [0:15];
            saved = blk;
            for (int i = 0; i < 16; i++) nxt[i] = rnd_coef();
            for (int i = 0; i < 16; i++) blk[i] = 16'($urandom);
            wait_done(16);
            blk = saved;
            check_results(16);
            blk = nxt;
            @(posedge clk);
            #1;
            check("b2b_ov_drop", 32'(obs_ov), 32'd0);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("b2b_ov_low", 32'(obs_ov), 32'd0);
            wait_done(15);
            check_results(16);
        end

        // 4-coefficient build
        use4 = 1'b1;
        clear_blk();
        blk[0] = 16'sd1; blk[3] = 16'sd1;
        run_block(4);
        check("n4_tz", 32'(obs_tz), 32'd2);
        check("n4_rb0", 32'(obs_rb[0]), 32'd2);
        for (int r = 0; r < 10; r++) begin
            rand_blk();
            run_block(4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule
